// File: rtl/as_gpio_port.sv
// Memory-mapped GPIO port: DATA_OUT/DIR registers, synchronised DATA_IN, and a
// cs_o strobe that frames every DATA_OUT update before the bus is acknowledged.
module as_gpio_port #(
  parameter int NR_GPIOS  = 8,
  parameter int CS_CYCLES = 2,
  parameter int ADDR_W    = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sel_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [63:0]         wdata_i,
  output logic [63:0]         rdata_o,
  output logic                ack_o,
  output logic [NR_GPIOS-1:0] gpio_o,
  output logic [NR_GPIOS-1:0] gpio_oe_o,
  input  logic [NR_GPIOS-1:0] gpio_i,
  output logic                cs_o,
  output logic [ADDR_W-1:0]   gpio_addr_o
);

  localparam int CNT_W = (CS_CYCLES > 1) ? $clog2(CS_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] OFF_DOUT = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] OFF_DIR  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] OFF_DIN  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] OFF_STAT = ADDR_W'(3);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_cs;
  logic                r_ack;
  logic [63:0]         r_rdata;
  logic [NR_GPIOS-1:0] r_data_out;
  logic [NR_GPIOS-1:0] r_dir;
  logic [NR_GPIOS-1:0] r_sync1;
  logic [NR_GPIOS-1:0] r_sync2;
  logic [ADDR_W-1:0]   r_gpio_addr;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_cs_nxt;
  logic                w_ack_nxt;
  logic [63:0]         w_rdata_nxt;
  logic [NR_GPIOS-1:0] w_data_out_nxt;
  logic [NR_GPIOS-1:0] w_dir_nxt;
  logic [ADDR_W-1:0]   w_gpio_addr_nxt;
  logic [NR_GPIOS-1:0] w_data_in;
  logic [63:0]         w_rd_val;
  logic                w_busy;
  logic                w_unused;

  // Output pins reflect the loop-back value, input pins the synchronised value.
  assign w_data_in = (r_sync2 & ~r_dir) | (r_data_out & r_dir);
  assign w_busy    = (r_state != ST_IDLE);
  assign w_unused  = ^wdata_i;

  // Read-data mux over the register map; unmapped offsets read as zero.
  always_comb begin
    w_rd_val = 64'd0;
    case (addr_i)
      OFF_DOUT: w_rd_val = 64'(r_data_out);
      OFF_DIR:  w_rd_val = 64'(r_dir);
      OFF_DIN:  w_rd_val = 64'(w_data_in);
      OFF_STAT: w_rd_val = {62'd0, w_busy, r_cs};
      default:  w_rd_val = 64'd0;
    endcase
  end

  // Next-state and next-register logic for the bus/strobe sequencer.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_cs_nxt        = r_cs;
    w_ack_nxt       = 1'b0;
    w_rdata_nxt     = 64'd0;
    w_data_out_nxt  = r_data_out;
    w_dir_nxt       = r_dir;
    w_gpio_addr_nxt = r_gpio_addr;
    case (r_state)
      ST_IDLE: begin
        // r_ack blocks the still-high sel_i of the request just acknowledged.
        if (sel_i && !r_ack) begin
          if (!we_i) begin
            w_ack_nxt   = 1'b1;
            w_rdata_nxt = w_rd_val;
          end else if (addr_i == OFF_DOUT) begin
            w_data_out_nxt  = wdata_i[NR_GPIOS-1:0];
            w_gpio_addr_nxt = addr_i;
            w_cs_nxt        = 1'b1;
            w_cnt_nxt       = CNT_W'(CS_CYCLES - 1);
            w_state_nxt     = ST_STROBE;
          end else begin
            if (addr_i == OFF_DIR) begin
              w_dir_nxt = wdata_i[NR_GPIOS-1:0];
            end else begin
              w_dir_nxt = r_dir;
            end
            w_ack_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_STROBE: begin
        if (r_cnt == CNT_W'(0)) begin
          w_cs_nxt    = 1'b0;
          w_ack_nxt   = 1'b1;
          w_state_nxt = ST_ACK;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_ACK: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cs_nxt    = 1'b0;
        w_cnt_nxt   = CNT_W'(0);
      end
    endcase
  end

  // State, register file and input synchroniser.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= CNT_W'(0);
      r_cs        <= 1'b0;
      r_ack       <= 1'b0;
      r_rdata     <= 64'd0;
      r_data_out  <= '0;
      r_dir       <= '0;
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_gpio_addr <= ADDR_W'(0);
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cs        <= w_cs_nxt;
      r_ack       <= w_ack_nxt;
      r_rdata     <= w_rdata_nxt;
      r_data_out  <= w_data_out_nxt;
      r_dir       <= w_dir_nxt;
      r_sync1     <= gpio_i;
      r_sync2     <= r_sync1;
      r_gpio_addr <= w_gpio_addr_nxt;
    end
  end

  assign rdata_o     = r_rdata;
  assign ack_o       = r_ack;
  assign cs_o        = r_cs;
  assign gpio_addr_o = r_gpio_addr;
  assign gpio_o      = r_data_out & r_dir;
  assign gpio_oe_o   = r_dir;

endmodule

// File: tb/tb_as_gpio_port.sv
// Scoreboard bench for as_gpio_port: one instance with CS_CYCLES=2, one with
// CS_CYCLES=1 for back-to-back strobe behaviour.
module tb_as_gpio_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  gpio_in;

  logic        sel_a, we_a, ack_a, cs_a;
  logic [1:0]  addr_a, gaddr_a;
  logic [63:0] wdata_a, rdata_a;
  logic [7:0]  gpio_a, oe_a;

  logic        sel_b, we_b, ack_b, cs_b;
  logic [1:0]  addr_b, gaddr_b;
  logic [63:0] wdata_b, rdata_b;
  logic [7:0]  gpio_b, oe_b;

  as_gpio_port #(.NR_GPIOS(8), .CS_CYCLES(2), .ADDR_W(2)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .sel_i(sel_a), .we_i(we_a), .addr_i(addr_a),
    .wdata_i(wdata_a), .rdata_o(rdata_a), .ack_o(ack_a), .gpio_o(gpio_a),
    .gpio_oe_o(oe_a), .gpio_i(gpio_in), .cs_o(cs_a), .gpio_addr_o(gaddr_a)
  );

  as_gpio_port #(.NR_GPIOS(8), .CS_CYCLES(1), .ADDR_W(2)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .sel_i(sel_b), .we_i(we_b), .addr_i(addr_b),
    .wdata_i(wdata_b), .rdata_o(rdata_b), .ack_o(ack_b), .gpio_o(gpio_b),
    .gpio_oe_o(oe_b), .gpio_i(gpio_in), .cs_o(cs_b), .gpio_addr_o(gaddr_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] q_a[$];
  logic [63:0] q_b[$];
  int cs_run[2];
  int ack_cnt[2];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Monitor: count strobe cycles and check every acknowledged response.
  always @(negedge clk) begin
    if (cs_a === 1'b1) cs_run[0]++;
    if (cs_b === 1'b1) cs_run[1]++;
    if (ack_a === 1'b1) begin
      ack_cnt[0]++;
      if (q_a.size() == 0) chk("unexpected_ack_a", 64'd1, 64'd0);
      else chk("rdata_a", rdata_a, q_a.pop_front());
    end
    if (ack_b === 1'b1) begin
      ack_cnt[1]++;
      if (q_b.size() == 0) chk("unexpected_ack_b", 64'd1, 64'd0);
      else chk("rdata_b", rdata_b, q_b.pop_front());
    end
  end

  task automatic xfer(input int d, input logic we, input logic [1:0] addr,
                      input logic [63:0] wd, input logic [63:0] exp_rd,
                      input int exp_lat, input int exp_cs, input string name);
    int n;
    logic a;
    @(negedge clk);
    cs_run[d] = 0;
    if (d == 0) begin
      q_a.push_back(exp_rd);
      sel_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd;
    end else begin
      q_b.push_back(exp_rd);
      sel_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd;
    end
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      a = (d == 0) ? ack_a : ack_b;
    end while (a !== 1'b1 && n < 20);
    chk({name, "_latency"}, 64'(n), 64'(exp_lat));
    chk({name, "_cs_len"}, 64'(cs_run[d]), 64'(exp_cs));
    if (d == 0) sel_a = 1'b0;
    else sel_b = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int acks;
    logic [7:0] vals[3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    rst = 1'b1; gpio_in = 8'h00;
    sel_a = 1'b0; we_a = 1'b0; addr_a = 2'd0; wdata_a = 64'd0;
    sel_b = 1'b0; we_b = 1'b0; addr_b = 2'd0; wdata_b = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gpio", 64'(gpio_a), 64'h0);
    chk("rst_oe", 64'(oe_a), 64'h0);
    chk("rst_cs", 64'(cs_a), 64'h0);
    chk("rst_ack", 64'(ack_a), 64'h0);
    chk("rst_rdata", rdata_a, 64'h0);
    chk("rst_gaddr", 64'(gaddr_a), 64'h0);
    chk("rst_gpio_b", 64'(gpio_b), 64'h0);
    rst = 1'b0;

    // DIR all outputs, then DATA_OUT 0x1D with a two-cycle strobe.
    xfer(0, 1'b1, 2'd1, 64'h0000_0000_0000_00FF, 64'h0, 1, 0, "wr_dir_ff");
    xfer(0, 1'b1, 2'd0, 64'h0000_0000_0000_001D, 64'h0, 3, 2, "wr_dout_1d");
    chk("gpio_1d", 64'(gpio_a), 64'h1D);
    chk("gaddr_dout", 64'(gaddr_a), 64'h0);
    xfer(0, 1'b0, 2'd0, 64'h0, 64'h1D, 1, 0, "rd_dout");
    xfer(0, 1'b0, 2'd1, 64'h0, 64'hFF, 1, 0, "rd_dir");

    // Mixed direction, upper write-data bits must be dropped.
    xfer(0, 1'b1, 2'd1, 64'hFFFF_FFFF_FFFF_FF0F, 64'h0, 1, 0, "wr_dir_0f");
    xfer(0, 1'b1, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3, 2, "wr_dout_ff");
    chk("gpio_masked", 64'(gpio_a), 64'h0F);
    chk("oe_0f", 64'(oe_a), 64'h0F);
    gpio_in = 8'hA0;
    repeat (3) @(posedge clk);
    xfer(0, 1'b0, 2'd2, 64'h0, 64'hAF, 1, 0, "rd_din");

    // Read-only and status offsets.
    xfer(0, 1'b1, 2'd2, 64'h55, 64'h0, 1, 0, "wr_din");
    xfer(0, 1'b1, 2'd3, 64'h55, 64'h0, 1, 0, "wr_stat");
    xfer(0, 1'b0, 2'd2, 64'h0, 64'hAF, 1, 0, "rd_din_again");
    xfer(0, 1'b0, 2'd3, 64'h0, 64'h0, 1, 0, "rd_stat");

    // Reset in the middle of a strobe aborts the transfer silently.
    @(negedge clk);
    sel_a = 1'b1; we_a = 1'b1; addr_a = 2'd0; wdata_a = 64'h3C;
    @(posedge clk); #1;
    chk("abort_cs_high", 64'(cs_a), 64'h1);
    @(negedge clk);
    rst = 1'b1; sel_a = 1'b0;
    acks = ack_cnt[0];
    @(posedge clk); #1;
    chk("abort_cs_low", 64'(cs_a), 64'h0);
    chk("abort_gpio", 64'(gpio_a), 64'h0);
    chk("abort_oe", 64'(oe_a), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("abort_no_ack", 64'(ack_cnt[0]), 64'(acks));
    xfer(0, 1'b1, 2'd1, 64'hFF, 64'h0, 1, 0, "post_rst_dir");
    xfer(0, 1'b1, 2'd0, 64'h3C, 64'h0, 3, 2, "post_rst_dout");
    chk("gpio_3c", 64'(gpio_a), 64'h3C);

    // Single-cycle strobes, back to back.
    xfer(1, 1'b1, 2'd1, 64'hFF, 64'h0, 1, 0, "b_wr_dir");
    for (int i = 0; i < 3; i++) begin
      xfer(1, 1'b1, 2'd0, 64'(vals[i]), 64'h0, 2, 1, "b_wr_dout");
      chk("b_gpio", 64'(gpio_b), 64'(vals[i]));
    end

    repeat (3) @(posedge clk); #1;
    chk("q_a_drained", 64'(q_a.size()), 64'h0);
    chk("q_b_drained", 64'(q_b.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
